// File: rtl/hline_setup.sv
// Span setup for the horizontal-line z-buffer engine: orders the endpoints, then forms addresses and the z slope.
// Optional HLINE_SETUP_PERF_EN adds the perf_cycles/perf_lines busy and line counters.
module hline_setup #(
    parameter int FB_BPP_SHIFT = 2,
    parameter int ZB_BPP_SHIFT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] x1,
    input  logic [15:0] x2,
    input  logic [15:0] y,
    input  logic [31:0] z1_in,
    input  logic [31:0] z2_in,
    input  logic [31:0] rgbx_in,
    input  logic [31:0] fb_base,
    input  logic [31:0] zb_base,
    input  logic [15:0] stride,
    input  logic        hline_done,
    output logic        hline_start,
    output logic [31:0] fb_addr,
    output logic [31:0] zbuff_addr,
    output logic [31:0] dx,
    output logic [31:0] slope,
    output logic [31:0] rem,
    output logic [31:0] err,
    output logic [31:0] z1,
    output logic [31:0] rgbx,
    output logic        busy,
`ifdef HLINE_SETUP_PERF_EN
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_lines,
`endif
    output logic        line_done
);

    typedef enum logic [2:0] {
        S_IDLE, S_ORDER, S_MUL, S_DIV, S_ISSUE, S_ARM, S_WAIT, S_FIN
    } state_t;

    state_t state, state_n;
    logic [5:0] cnt;

    logic [15:0] c_x1, c_x2, c_y, c_stride;
    logic [31:0] c_z1, c_z2, c_rgbx, c_fb, c_zb;

    logic [15:0] xl_r;
    logic [16:0] dx_r;
    logic [31:0] zl_r;
    logic        neg_r;
    logic [31:0] mcand, prod, fb_w, zb_w, dvd;
    logic [15:0] mplier;
    logic [16:0] prem;

    function automatic logic [31:0] mag32(input logic signed [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [31:0] apply_sign(input logic [31:0] m, input logic n);
        return n ? (~m + 32'd1) : m;
    endfunction

    // Endpoint ordering; endpoint A wins a tie in x.
    logic               a_left;
    logic [15:0]        xl_c, xr_c;
    logic [31:0]        zl_c, zr_c;
    logic signed [31:0] dz_c;
    logic [16:0]        dx_c;

    assign a_left = (c_x1 <= c_x2);
    assign xl_c   = a_left ? c_x1 : c_x2;
    assign xr_c   = a_left ? c_x2 : c_x1;
    assign zl_c   = a_left ? c_z1 : c_z2;
    assign zr_c   = a_left ? c_z2 : c_z1;
    assign dx_c   = {1'b0, xr_c} - {1'b0, xl_c} + 17'd1;
    assign dz_c   = signed'(zr_c - zl_c);

    // Restoring divide step: the borrow out of the trial subtract decides the quotient bit.
    logic [17:0] shifted, diff;
    logic        ge;
    logic [16:0] prem_n;
    logic [31:0] dvd_n;
    logic [31:0] pix;

    assign shifted = {prem, dvd[31]};
    assign diff    = shifted - {1'b0, dx_r};
    assign ge      = ~diff[17];
    assign prem_n  = ge ? diff[16:0] : shifted[16:0];
    assign dvd_n   = {dvd[30:0], ge};
    assign pix     = prod + {16'd0, xl_r};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        busy        = 1'b1;
        hline_start = 1'b0;
        line_done   = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_n = S_ORDER;
            end
            S_ORDER: state_n = S_MUL;
            S_MUL:   if (cnt == 6'd16) state_n = S_DIV;
            S_DIV:   if (cnt == 6'd31) state_n = S_ISSUE;
            S_ISSUE: begin
                hline_start = 1'b1;
                state_n     = S_ARM;
            end
            // A done level left over from the previous line must drop first.
            S_ARM:   if (!hline_done) state_n = S_WAIT;
            S_WAIT:  if (hline_done) state_n = S_FIN;
            S_FIN: begin
                line_done = 1'b1;
                state_n   = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            c_x1 <= '0; c_x2 <= '0; c_y <= '0; c_stride <= '0;
            c_z1 <= '0; c_z2 <= '0; c_rgbx <= '0; c_fb <= '0; c_zb <= '0;
            xl_r <= '0; dx_r <= '0; zl_r <= '0; neg_r <= 1'b0;
            mcand <= '0; mplier <= '0; prod <= '0; fb_w <= '0; zb_w <= '0;
            dvd <= '0; prem <= '0;
            fb_addr <= '0; zbuff_addr <= '0; dx <= '0; slope <= '0;
            rem <= '0; z1 <= '0; rgbx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        c_x1 <= x1; c_x2 <= x2; c_y <= y; c_stride <= stride;
                        c_z1 <= z1_in; c_z2 <= z2_in; c_rgbx <= rgbx_in;
                        c_fb <= fb_base; c_zb <= zb_base;
                    end
                end
                S_ORDER: begin
                    xl_r   <= xl_c;
                    dx_r   <= dx_c;
                    zl_r   <= zl_c;
                    neg_r  <= dz_c[31];
                    dvd    <= mag32(dz_c);
                    prem   <= '0;
                    mcand  <= {16'd0, c_y};
                    mplier <= c_stride;
                    prod   <= '0;
                    cnt    <= '0;
                end
                // 16 shift-add steps, then one cycle to form both byte addresses.
                S_MUL: begin
                    if (cnt == 6'd16) begin
                        fb_w <= c_fb + (pix << FB_BPP_SHIFT);
                        zb_w <= c_zb + (pix << ZB_BPP_SHIFT);
                        cnt  <= '0;
                    end else begin
                        if (mplier[0]) prod <= prod + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 6'd1;
                    end
                end
                S_DIV: begin
                    prem <= prem_n;
                    dvd  <= dvd_n;
                    cnt  <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        fb_addr    <= fb_w;
                        zbuff_addr <= zb_w;
                        dx         <= {15'd0, dx_r};
                        slope      <= apply_sign(dvd_n, neg_r);
                        rem        <= {15'd0, prem_n};
                        z1         <= zl_r;
                        rgbx       <= c_rgbx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign err = 32'd0;

`ifdef HLINE_SETUP_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_cycles <= '0;
            perf_lines  <= '0;
        end else begin
            if (busy)      perf_cycles <= perf_cycles + 32'd1;
            if (line_done) perf_lines  <= perf_lines + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hline_setup.sv
// Randomized bench for hline_setup with a span-level reference model and an emulated z-buffer engine.
module tb_hline_setup;
    localparam int FB = 2;
    localparam int ZB = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] x1 = '0, x2 = '0, y = '0, stride = '0;
    logic [31:0] z1_in = '0, z2_in = '0, rgbx_in = '0, fb_base = '0, zb_base = '0;
    logic        hline_done = 1'b0;
    logic        hline_start, busy, line_done;
    logic [31:0] fb_addr, zbuff_addr, dx, slope, rem, err, z1, rgbx;
`ifdef HLINE_SETUP_PERF_EN
    logic [31:0] perf_cycles, perf_lines;
`endif

    hline_setup #(.FB_BPP_SHIFT(FB), .ZB_BPP_SHIFT(ZB)) dut (
        .clk(clk), .reset(reset), .start(start),
        .x1(x1), .x2(x2), .y(y), .z1_in(z1_in), .z2_in(z2_in), .rgbx_in(rgbx_in),
        .fb_base(fb_base), .zb_base(zb_base), .stride(stride), .hline_done(hline_done),
        .hline_start(hline_start), .fb_addr(fb_addr), .zbuff_addr(zbuff_addr),
        .dx(dx), .slope(slope), .rem(rem), .err(err), .z1(z1), .rgbx(rgbx),
        .busy(busy),
`ifdef HLINE_SETUP_PERF_EN
        .perf_cycles(perf_cycles), .perf_lines(perf_lines),
`endif
        .line_done(line_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] fb, zb, dx, slope, rem, z1, rgbx;
    } params_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Span parameters straight from the arithmetic definitions.
    function automatic params_t span_model(input logic [15:0] ax, bx, yy, st,
                                           input logic [31:0] az, bz, col, fbb, zbb);
        params_t p;
        longint xl, xr, dxl, sdz, q, mag, r;
        logic [31:0] zl, zr, dz, pix;
        if (ax <= bx) begin xl = ax; xr = bx; zl = az; zr = bz; end
        else          begin xl = bx; xr = ax; zl = bz; zr = az; end
        dz  = zr - zl;
        dxl = xr - xl + 1;
        sdz = longint'($signed(dz));
        q   = sdz / dxl;
        mag = (sdz < 0) ? -sdz : sdz;
        r   = mag % dxl;
        pix = 32'(longint'(yy) * longint'(st) + xl);
        p.fb    = fbb + (pix << FB);
        p.zb    = zbb + (pix << ZB);
        p.dx    = 32'(dxl);
        p.slope = 32'(q);
        p.rem   = 32'(r);
        p.z1    = zl;
        p.rgbx  = col;
        return p;
    endfunction

    // Transaction-level model: accept, fixed 50-edge setup, engine handshake, completion.
    bit          m_active = 0, m_low = 0, m_fin = 0;
    int          m_edges = 0;
    params_t     m_pend = '0, m_out = '0;
    logic [31:0] m_cyc = '0, m_lines = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 0; m_low = 0; m_fin = 0; m_edges = 0;
            m_pend = '0; m_out = '0; m_cyc = '0; m_lines = '0;
        end else begin
            if (m_active) m_cyc = m_cyc + 32'd1;
            if (m_fin)    m_lines = m_lines + 32'd1;
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_edges = 0; m_low = 0; m_fin = 0;
                    m_pend = span_model(x1, x2, y, stride, z1_in, z2_in, rgbx_in, fb_base, zb_base);
                end
            end else if (m_fin) begin
                m_active = 0; m_fin = 0;
            end else begin
                m_edges++;
                if (m_edges == 50) m_out = m_pend;
                else if (m_edges >= 52) begin
                    if (!m_low) begin
                        if (!hline_done) m_low = 1;
                    end else if (hline_done) m_fin = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        params_t e;
        logic eb, ehs, eld;
        if (reset) begin
            e = '0; eb = 0; ehs = 0; eld = 0;
        end else begin
            e = m_out; eb = m_active; ehs = m_active && (m_edges == 50); eld = m_fin;
        end
        chk("busy", {31'd0, busy}, {31'd0, eb});
        chk("hline_start", {31'd0, hline_start}, {31'd0, ehs});
        chk("line_done", {31'd0, line_done}, {31'd0, eld});
        if (reset || !m_active || m_edges >= 50) begin
            chk("fb_addr", fb_addr, e.fb);
            chk("zbuff_addr", zbuff_addr, e.zb);
            chk("dx", dx, e.dx);
            chk("slope", slope, e.slope);
            chk("rem", rem, e.rem);
            chk("err", err, 32'd0);
            chk("z1", z1, e.z1);
            chk("rgbx", rgbx, e.rgbx);
        end
`ifdef HLINE_SETUP_PERF_EN
        chk("perf_cycles", perf_cycles, reset ? 32'd0 : m_cyc);
        chk("perf_lines", perf_lines, reset ? 32'd0 : m_lines);
`endif
    end

    // Engine emulation: drop done eng_drop negedges after the start pulse, raise it eng_run later.
    int eng_drop = 0;
    int eng_run = 3;
    initial begin
        forever begin
            @(negedge clk);
            if (hline_start === 1'b1) begin
                repeat (eng_drop) @(negedge clk);
                hline_done = 1'b0;
                repeat (eng_run) @(negedge clk);
                hline_done = 1'b1;
            end
        end
    end

    task automatic run_span(input logic [15:0] ax, bx, yy, st,
                            input logic [31:0] az, bz, col, fbb, zbb, output params_t got);
        int lat;
        bit seen, fin_seen;
        @(posedge clk); #1;
        x1 = ax; x2 = bx; y = yy; stride = st;
        z1_in = az; z2_in = bz; rgbx_in = col; fb_base = fbb; zb_base = zbb;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0; seen = 0; fin_seen = 0; got = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (hline_start) begin seen = 1; break; end
            @(posedge clk);
            lat++;
            if (lat == 20) begin
                #1;
                start = 1'b1;
                x1 = 16'($urandom); x2 = 16'($urandom); z1_in = $urandom; fb_base = $urandom;
            end else if (lat == 21) begin
                #1;
                start = 1'b0;
            end
        end
        chk("latency", seen ? lat : -1, 32'd50);
        got = '{fb_addr, zbuff_addr, dx, slope, rem, z1, rgbx};
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (line_done) begin fin_seen = 1; break; end
        end
        chk("line_done_seen", {31'd0, fin_seen}, 32'd1);
        @(posedge clk);
    endtask

    task automatic pin(input string nm, input params_t g, input logic [31:0] efb, ezb,
                       edx, esl, erm, ez1);
        chk({nm, "_fb"}, g.fb, efb);
        chk({nm, "_zb"}, g.zb, ezb);
        chk({nm, "_dx"}, g.dx, edx);
        chk({nm, "_slope"}, g.slope, esl);
        chk({nm, "_rem"}, g.rem, erm);
        chk({nm, "_z1"}, g.z1, ez1);
    endtask

    initial begin
        params_t g;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fb", fb_addr, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        eng_drop = 0; eng_run = 3;
        run_span(16'd10, 16'd19, 16'd3, 16'd2560, 32'd100, 32'd130, 32'h11223344,
                 32'h10000000, 32'h20000000, g);
        pin("basic", g, 32'h10007828, 32'h20007828, 32'd10, 32'd3, 32'd0, 32'd100);
        chk("basic_rgbx", g.rgbx, 32'h11223344);

        eng_drop = 3; eng_run = 4;
        run_span(16'd19, 16'd10, 16'd3, 16'd2560, 32'd130, 32'd100, 32'h11223344,
                 32'h10000000, 32'h20000000, g);
        pin("swap", g, 32'h10007828, 32'h20007828, 32'd10, 32'd3, 32'd0, 32'd100);

        eng_drop = 1; eng_run = 2;
        run_span(16'd0, 16'd6, 16'd3, 16'd2560, 32'd50, 32'd30, 32'h0,
                 32'h10000000, 32'h20000000, g);
        pin("neg", g, 32'h10007800, 32'h20007800, 32'd7, 32'hFFFFFFFE, 32'd6, 32'd50);

        run_span(16'd5, 16'd5, 16'd0, 16'd0, 32'd7, 32'd99, 32'h0, 32'h0, 32'h0, g);
        pin("single", g, 32'd20, 32'd20, 32'd1, 32'd92, 32'd0, 32'd7);

        run_span(16'd65535, 16'd0, 16'd0, 16'd0, 32'h80000000, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h0, g);
        pin("wide", g, 32'd0, 32'd0, 32'h10000, 32'd0, 32'd1, 32'h7FFFFFFF);

        run_span(16'd0, 16'd0, 16'd0, 16'd0, 32'd0, 32'h80000000, 32'h0, 32'h0, 32'h0, g);
        pin("zmin", g, 32'd0, 32'd0, 32'd1, 32'h80000000, 32'd0, 32'd0);

        for (int n = 0; n < 10; n++) begin
            eng_drop = $urandom_range(0, 3);
            eng_run  = $urandom_range(1, 6);
            run_span(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                     $urandom, $urandom, $urandom, $urandom, $urandom, g);
        end

        // Reset in the middle of the divide.
        @(posedge clk); #1;
        x1 = 16'd10; x2 = 16'd19; y = 16'd3; stride = 16'd2560;
        z1_in = 32'd100; z2_in = 32'd130; fb_base = 32'h10000000; zb_base = 32'h20000000;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_slope", slope, 32'd0);
        chk("midrst_fb", fb_addr, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        eng_drop = 0; eng_run = 2;
        run_span(16'd10, 16'd19, 16'd3, 16'd2560, 32'd100, 32'd130, 32'h0,
                 32'h10000000, 32'h20000000, g);
        pin("after_rst", g, 32'h10007828, 32'h20007828, 32'd10, 32'd3, 32'd0, 32'd100);

`ifdef HLINE_SETUP_PERF_EN
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        eng_drop = 0; eng_run = 5;
        run_span(16'd10, 16'd19, 16'd3, 16'd2560, 32'd100, 32'd130, 32'h0,
                 32'h10000000, 32'h20000000, g);
        run_span(16'd0, 16'd6, 16'd3, 16'd2560, 32'd50, 32'd30, 32'h0,
                 32'h10000000, 32'h20000000, g);
        @(negedge clk);
        chk("perf_lines_total", perf_lines, 32'd2);
        chk("perf_cycles_total", perf_cycles, 32'd114);
`endif

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end
endmodule
